// File: rtl/os_result_drain_pkg.sv
// os_result_drain_pkg
//   Shared definitions for the output-stationary array read-out blocks.
//   - state_e : drain controller states (IDLE / DRAIN / CLEAR)
//   - clog2   : ceiling log2 with a floor of 1, usable in constant expressions
package os_result_drain_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_CLEAR = 2'd2
   } state_e;

   // Minimum of 1 so that degenerate sizes still yield a legal vector width.
   function automatic int clog2(input int v);
      int r;
      r = 1;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/os_result_drain_result_fifo.sv
// result_fifo
//   Synchronous FIFO holding deskewed result rows until downstream takes them.
//   Ports:
//     clk, rst      clock, synchronous active-high reset (pointers/count only)
//     push, din     write request and data (ignored when full)
//     pop           read request (ignored when empty)
//     dout          head entry, forced to 0 while empty
//     full, empty   occupancy flags
//     count         number of stored entries
module result_fifo
   import os_result_drain_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic [WIDTH-1:0]              din,
   input  logic                          pop,
   output logic [WIDTH-1:0]              dout,
   output logic                          full,
   output logic                          empty,
   output logic [clog2(DEPTH+1)-1:0]     count
);

   localparam int AW = clog2(DEPTH);
   localparam int CW = clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [CW-1:0]    cnt_q;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign count   = cnt_q;
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   // Head is masked while empty so the outputs read 0 out of reset.
   assign dout    = empty ? '0 : mem_q[rd_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_ok) wr_q <= wr_q + AW'(1);
         if (pop_ok)  rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= din;
   end

endmodule

// File: rtl/os_result_drain.sv
// os_result_drain
//   Read-out end of the output-stationary array. After compute it shifts the
//   accumulated results out of the column chains, removes the per-column skew,
//   narrows every element and streams one full row per beat over valid/ready.
//   Ports:
//     clk, rst       clock, synchronous active-high reset
//     start          pulse, begins a drain when idle
//     col_mac        bottom MAC_out of each column, col c at [c*WIDTH_MAC +: WIDTH_MAC]
//     arr_shift_en   advances the array result chains one step
//     arr_clear      one-cycle pulse clearing the accumulators after a drain
//     busy           high from accepted start until back in IDLE
//     done           one-cycle pulse once the last row is in the FIFO
//     m_valid/m_ready/m_data/m_row/m_last   output row stream
module os_result_drain
   import os_result_drain_pkg::*;
#(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int WIDTH_MAC  = 48,
   parameter int OUT_W      = 32,
   parameter int SIGNED     = 0,
   parameter int SAT        = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [COLS*WIDTH_MAC-1:0]    col_mac,
   output logic                         arr_shift_en,
   output logic                         arr_clear,
   output logic                         busy,
   output logic                         done,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [COLS*OUT_W-1:0]        m_data,
   output logic [clog2(ROWS)-1:0]       m_row,
   output logic                         m_last
);

   localparam int RW  = clog2(ROWS);
   localparam int CW  = clog2(ROWS + COLS);
   localparam int FCW = clog2(FIFO_DEPTH + 1);
   localparam int FW  = COLS*OUT_W + RW + 1;

   localparam logic        [WIDTH_MAC-1:0] UMAX = (WIDTH_MAC'(1) << OUT_W) - WIDTH_MAC'(1);
   localparam logic signed [WIDTH_MAC-1:0] SMAX = signed'((WIDTH_MAC'(1) << (OUT_W-1)) - WIDTH_MAC'(1));
   localparam logic signed [WIDTH_MAC-1:0] SMIN = ~SMAX;

   // Accumulator -> output width: clamp when saturating, otherwise truncate.
   function automatic logic [OUT_W-1:0] narrow(input logic [WIDTH_MAC-1:0] v);
      logic        [WIDTH_MAC-1:0] r;
      logic signed [WIDTH_MAC-1:0] sv;
      r  = v;
      sv = signed'(v);
      if (SAT != 0) begin
         if (SIGNED != 0) begin
            if (sv > SMAX)      r = SMAX;
            else if (sv < SMIN) r = SMIN;
         end else if (v > UMAX) begin
            r = UMAX;
         end
      end
      return r[OUT_W-1:0];
   endfunction

   state_e           state_q;
   logic [CW-1:0]    shift_cnt_q;
   logic             done_q;
   logic             clr_q;

   logic [FCW-1:0]   fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic [FW-1:0]    fifo_dout;
   logic             push;
   logic [RW-1:0]    push_row;
   logic             push_last;

   logic [WIDTH_MAC-1:0] aligned [COLS];
   logic [COLS*OUT_W-1:0] row_narrow;

   // Depends only on registered state and occupancy, never on m_ready.
   assign arr_shift_en = (state_q == ST_DRAIN) && (fifo_count < FCW'(FIFO_DEPTH));
   assign busy         = (state_q != ST_IDLE);
   assign done         = done_q;
   assign arr_clear    = clr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         shift_cnt_q <= '0;
         done_q      <= 1'b0;
         clr_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         clr_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q     <= ST_DRAIN;
                  shift_cnt_q <= '0;
               end
            end
            ST_DRAIN: begin
               if (arr_shift_en) begin
                  if (shift_cnt_q == CW'(ROWS + COLS - 2)) begin
                     state_q <= ST_CLEAR;
                     done_q  <= 1'b1;
                     clr_q   <= 1'b1;
                  end else begin
                     shift_cnt_q <= shift_cnt_q + CW'(1);
                  end
               end
            end
            ST_CLEAR: state_q <= ST_IDLE;
            default:  state_q <= ST_IDLE;
         endcase
      end
   end

   // Column c runs c beats behind column 0; delaying it COLS-1-c beats lines
   // every column up with the last one, which is used as presented.
   for (genvar c = 0; c < COLS; c++) begin : g_col
      if (c < COLS - 1) begin : g_dly
         localparam int D = COLS - 1 - c;
         logic [WIDTH_MAC-1:0] line_q [D];
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int k = 0; k < D; k++) line_q[k] <= '0;
            end else if (arr_shift_en) begin
               line_q[0] <= col_mac[c*WIDTH_MAC +: WIDTH_MAC];
               for (int k = 1; k < D; k++) line_q[k] <= line_q[k-1];
            end
         end
         assign aligned[c] = line_q[D-1];
      end else begin : g_pass
         assign aligned[c] = col_mac[c*WIDTH_MAC +: WIDTH_MAC];
      end
      assign row_narrow[c*OUT_W +: OUT_W] = narrow(aligned[c]);
   end

   // The first COLS-1 beats only fill the delay lines; afterwards each beat
   // completes the row that entered column 0 COLS-1 beats earlier.
   assign push      = arr_shift_en && (shift_cnt_q >= CW'(COLS - 1));
   assign push_row  = RW'(shift_cnt_q - CW'(COLS - 1));
   assign push_last = (push_row == RW'(ROWS - 1));

   result_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   ({push_last, push_row, row_narrow}),
      .pop   (m_valid && m_ready),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign m_valid = !fifo_empty;
   assign {m_last, m_row, m_data} = fifo_dout;

endmodule

// File: tb/tb_os_result_drain.sv
// tb_os_result_drain
//   Directed bench for os_result_drain with a row scoreboard. Three instances
//   share stimulus: unsigned saturating (main), signed saturating, and
//   truncating; a small array model presents col_mac per shift beat.
module tb_os_result_drain;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          m_ready;
   logic [191:0]  col_mac;

   logic          sh_a, clr_a, busy_a, done_a, v_a, last_a;
   logic [127:0]  d_a;
   logic [1:0]    row_a;
   logic          sh_s, clr_s, busy_s, done_s, v_s, last_s;
   logic [127:0]  d_s;
   logic [1:0]    row_s;
   logic          sh_w, clr_w, busy_w, done_w, v_w, last_w;
   logic [127:0]  d_w;
   logic [1:0]    row_w;

   int            mode;
   int            seed;
   int            nb;
   int            tot_sh;
   int            n_done;
   int            n_clr;
   int            n_cmp;
   int            n_err;

   typedef struct {
      logic [127:0] a;
      logic [127:0] b;
      logic [127:0] w;
      logic [1:0]   row;
      logic         last;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   os_result_drain #(.ROWS(4), .COLS(4), .WIDTH_MAC(48), .OUT_W(32), .SIGNED(0), .SAT(1), .FIFO_DEPTH(4)) dut_a (
      .clk(clk), .rst(rst), .start(start), .col_mac(col_mac), .arr_shift_en(sh_a), .arr_clear(clr_a),
      .busy(busy_a), .done(done_a), .m_valid(v_a), .m_ready(m_ready), .m_data(d_a), .m_row(row_a), .m_last(last_a));

   os_result_drain #(.ROWS(4), .COLS(4), .WIDTH_MAC(48), .OUT_W(32), .SIGNED(1), .SAT(1), .FIFO_DEPTH(4)) dut_s (
      .clk(clk), .rst(rst), .start(start), .col_mac(col_mac), .arr_shift_en(sh_s), .arr_clear(clr_s),
      .busy(busy_s), .done(done_s), .m_valid(v_s), .m_ready(m_ready), .m_data(d_s), .m_row(row_s), .m_last(last_s));

   os_result_drain #(.ROWS(4), .COLS(4), .WIDTH_MAC(48), .OUT_W(32), .SIGNED(0), .SAT(0), .FIFO_DEPTH(4)) dut_w (
      .clk(clk), .rst(rst), .start(start), .col_mac(col_mac), .arr_shift_en(sh_w), .arr_clear(clr_w),
      .busy(busy_w), .done(done_w), .m_valid(v_w), .m_ready(m_ready), .m_data(d_w), .m_row(row_w), .m_last(last_w));

   function automatic logic [47:0] elem(input int m, input int s, input int r, input int c);
      if (m == 0) return 48'(s*256 + 16*r + c);
      case (c)
         0:       return 48'h0100_0000_0000;   // 2^40
         1:       return 48'hFF00_0000_0000;   // -2^40
         2:       return 48'hFFFF_FFFF_FFFB;   // -5
         default: return 48'h0100_0000_0003;   // 2^40+3
      endcase
   endfunction

   // Array model: on beat n, column c shows row n-c; out-of-range rows are junk.
   always_comb begin
      col_mac = '0;
      for (int c = 0; c < 4; c++) begin
         if ((nb - c) >= 0 && (nb - c) < 4) col_mac[c*48 +: 48] = elem(mode, seed, nb - c, c);
         else                               col_mac[c*48 +: 48] = 48'hBAD0_0000_0000 | 48'(c);
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         nb <= 0;
      end else begin
         if (start && !busy_a) nb <= 0;
         else if (sh_a)        nb <= nb + 1;
         if (sh_a)   tot_sh <= tot_sh + 1;
         if (done_a) n_done <= n_done + 1;
         if (clr_a)  n_clr  <= n_clr + 1;
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_rows(input int m, input int s);
      for (int r = 0; r < 4; r++) begin
         exp_t e;
         e.row  = 2'(r);
         e.last = (r == 3);
         for (int c = 0; c < 4; c++) begin
            logic [31:0] bs, ws;
            if (m == 0) begin
               bs = 32'(s*256 + 16*r + c);
               e.a[c*32 +: 32] = bs;
               e.b[c*32 +: 32] = bs;
               e.w[c*32 +: 32] = bs;
            end else begin
               case (c)
                  0:       begin bs = 32'h7FFF_FFFF; ws = 32'h0000_0000; end
                  1:       begin bs = 32'h8000_0000; ws = 32'h0000_0000; end
                  2:       begin bs = 32'hFFFF_FFFB; ws = 32'hFFFF_FFFB; end
                  default: begin bs = 32'h7FFF_FFFF; ws = 32'h0000_0003; end
               endcase
               e.a[c*32 +: 32] = 32'hFFFF_FFFF;
               e.b[c*32 +: 32] = bs;
               e.w[c*32 +: 32] = ws;
            end
         end
         sb.push_back(e);
      end
   endtask

   task automatic pulse_start(input int m, input int s);
      mode = m;
      seed = s;
      push_rows(m, s);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input bit rnd);
      for (int i = 0; i < budget && busy_a; i++) begin
         if (rnd) m_ready = 1'($urandom_range(0, 1));
         tick();
      end
      chk("busy_timeout", 128'(busy_a), 128'(0));
   endtask

   task automatic wait_empty(input int budget);
      m_ready = 1'b1;
      for (int i = 0; i < budget && sb.size() != 0; i++) tick();
      chk("sb_drained", 128'(sb.size()), 128'(0));
   endtask

   initial begin
      int b_done, b_clr, b_sh, dcyc;
      n_cmp = 0; n_err = 0; tot_sh = 0; n_done = 0; n_clr = 0;
      rst = 1'b1; start = 1'b0; m_ready = 1'b1; mode = 0; seed = 0;

      fork
         forever begin
            @(negedge clk);
            if (!rst && v_a && m_ready) begin
               chk("sb_nonempty", 128'(sb.size() != 0), 128'(1));
               if (sb.size() != 0) begin
                  exp_t e;
                  e = sb.pop_front();
                  chk("row_data", d_a, e.a);
                  chk("row_idx", 128'({row_a, last_a}), 128'({e.row, e.last}));
                  chk("row_data_signed", d_s, e.b);
                  chk("row_data_trunc", d_w, e.w);
                  chk("row_idx_bc", 128'({v_s, row_s, last_s, v_w, row_w, last_w}),
                      128'({1'b1, e.row, e.last, 1'b1, e.row, e.last}));
               end
            end
         end
      join_none

      // Reset state
      tick(); tick();
      chk("rst_ctrl", 128'({sh_a, clr_a, busy_a, done_a, v_a, last_a, row_a}), 128'(0));
      chk("rst_data", d_a, 128'(0));
      rst = 1'b0;
      tick();

      // 1: plain drain, no backpressure, done timing
      b_done = n_done; b_clr = n_clr; b_sh = tot_sh;
      mode = 0; seed = 0; push_rows(0, 0);
      start = 1'b1; dcyc = -1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         start = 1'b0;
         if (k == 1) chk("t1_busy", 128'(busy_a), 128'(1));
         if (done_a === 1'b1 && dcyc < 0) dcyc = k;
      end
      chk("t1_done_cycle", 128'(dcyc), 128'(8));
      chk("t1_beats", 128'(tot_sh - b_sh), 128'(7));
      chk("t1_done_clr", 128'({n_done - b_done, n_clr - b_clr}), 128'({32'd1, 32'd1}));
      wait_empty(20);

      // 2: no ready through a drain, then a drain that must stall on the full FIFO
      m_ready = 1'b0; b_sh = tot_sh;
      pulse_start(0, 1);
      wait_idle(40, 1'b0);
      chk("t2_beats", 128'(tot_sh - b_sh), 128'(7));
      chk("t2_hold_valid", 128'({v_a, row_a}), 128'({1'b1, 2'd0}));
      chk("t2_hold_data", d_a, sb[0].a);
      pulse_start(0, 2);
      tick(); tick(); tick();
      chk("t2_stall", 128'({sh_a, busy_a}), 128'({1'b0, 1'b1}));
      chk("t2_stall_beats", 128'(nb), 128'(0));
      chk("t2_hold_data2", d_a, sb[0].a);
      m_ready = 1'b1;
      wait_idle(60, 1'b0);
      wait_empty(20);
      chk("t2_total_beats", 128'(tot_sh - b_sh), 128'(14));

      // 3: narrowing boundaries
      pulse_start(1, 0);
      wait_idle(40, 1'b0);
      wait_empty(20);
      chk("t3_bc_idle", 128'({sh_s, clr_s, busy_s, done_s, sh_w, clr_w, busy_w, done_w}), 128'(0));

      // 4: extra start pulses during DRAIN are ignored
      b_done = n_done; b_clr = n_clr; b_sh = tot_sh;
      pulse_start(0, 3);
      tick(); tick();
      start = 1'b1; tick(); start = 1'b0; tick();
      start = 1'b1; tick(); start = 1'b0;
      wait_idle(40, 1'b0);
      wait_empty(20);
      tick(); tick();
      chk("t4_done_clr", 128'({n_done - b_done, n_clr - b_clr}), 128'({32'd1, 32'd1}));
      chk("t4_beats", 128'(tot_sh - b_sh), 128'(7));

      // 5: reset at shift beat 3
      b_done = n_done; b_clr = n_clr;
      pulse_start(0, 4);
      for (int i = 0; i < 20 && nb != 3; i++) tick();
      chk("t5_reach_beat3", 128'(nb), 128'(3));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      chk("t5_after_rst", 128'({busy_a, v_a, done_a, clr_a}), 128'(0));
      tick(); tick();
      chk("t5_no_done", 128'({n_done - b_done, n_clr - b_clr}), 128'(0));
      pulse_start(0, 5);
      wait_idle(40, 1'b0);
      wait_empty(20);
      chk("t5_redrain_done", 128'(n_done - b_done), 128'(1));

      // 6: random ready, three back-to-back drains
      b_sh = tot_sh;
      for (int d = 0; d < 3; d++) begin
         pulse_start(0, 10 + d);
         wait_idle(300, 1'b1);
      end
      wait_empty(40);
      chk("t6_beats", 128'(tot_sh - b_sh), 128'(21));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
